// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: ROM address/data, redirect/halt controls and the
// decode-side valid/ready output. master = fetch controller, slave = its environment.
interface fetch_controller_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input  imem_instr, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr,
    output imem_instr, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, tracks the single in-flight ROM read
// and buffers returned words with their PC in a 2-entry FIFO toward decode.
module fetch_controller #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  fetch_controller_if.master  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  entry_t            fifo [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;

  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = fifo[rd_ptr].pc;
  assign bus.out_instr = fifo[rd_ptr].instr;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = inflight & ~bus.redirect_valid;

  // Credit check: a new read is only issued if its return is guaranteed a slot,
  // counting the read already in flight and the entry leaving this edge.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~bus.redirect_valid & ~bus.halt & (occ < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
    end else if (bus.redirect_valid) begin
      // Flush: the returning word and all buffered entries are dropped.
      pc_reg   <= bus.redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= wr_ptr;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_reg;
        pc_reg      <= pc_reg + ADDR_W'(4);
      end
      if (push) begin
        fifo[wr_ptr] <= {inflight_pc, bus.imem_instr};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle vector table for streaming,
// redirect and halt, plus hand sequences for backpressure, full-FIFO redirect and async reset.
module tb_fetch_controller;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_controller_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_controller #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered ROM, word[i] = i
  always_ff @(posedge clk) bus.imem_instr <= {2'b00, bus.imem_addr[31:2]};

  typedef struct {
    logic        rdy;
    logic        halt;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic rdy, logic halt, logic rv, logic [31:0] rpc,
                              logic ev, logic [31:0] eaddr, logic [31:0] epc, logic [31:0] einstr);
    vec_t v;
    v.rdy = rdy; v.halt = halt; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.eaddr = eaddr; v.epc = epc; v.einstr = einstr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive vector k's inputs for this cycle, then check the registered outputs.
  task automatic apply_vec(input int k);
    bus.out_ready      = tbl[k].rdy;
    bus.halt           = tbl[k].halt;
    bus.redirect_valid = tbl[k].rv;
    bus.redirect_pc    = tbl[k].rpc;
    #1;
    chk($sformatf("v%0d out_valid", k), {31'b0, bus.out_valid}, {31'b0, tbl[k].ev});
    chk($sformatf("v%0d imem_addr", k), bus.imem_addr, tbl[k].eaddr);
    if (tbl[k].ev) begin
      chk($sformatf("v%0d out_pc", k), bus.out_pc, tbl[k].epc);
      chk($sformatf("v%0d out_instr", k), bus.out_instr, tbl[k].einstr);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (k != lo) @(negedge clk);
      apply_vec(k);
    end
  endtask

  initial begin
    int w;
    bus.out_ready      = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Cycle 0 = first cycle after reset release; out_ready=1 throughout.
    tbl[0]  = mk(1, 0, 0, 32'h0,  0, 32'h00, 32'h0,  32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,  0, 32'h04, 32'h0,  32'h0);
    tbl[2]  = mk(1, 0, 0, 32'h0,  1, 32'h08, 32'h0,  32'h0);
    tbl[3]  = mk(1, 0, 0, 32'h0,  1, 32'h0C, 32'h4,  32'h1);
    tbl[4]  = mk(1, 0, 1, 32'h40, 1, 32'h10, 32'h8,  32'h2);   // redirect while pc 8 shown
    tbl[5]  = mk(1, 0, 0, 32'h0,  0, 32'h40, 32'h0,  32'h0);
    tbl[6]  = mk(1, 0, 0, 32'h0,  0, 32'h44, 32'h0,  32'h0);
    tbl[7]  = mk(1, 0, 0, 32'h0,  1, 32'h48, 32'h40, 32'h10);
    tbl[8]  = mk(1, 1, 0, 32'h0,  1, 32'h4C, 32'h44, 32'h11);  // halt for 10 cycles
    tbl[9]  = mk(1, 1, 0, 32'h0,  1, 32'h4C, 32'h48, 32'h12);
    for (int k = 10; k <= 17; k++)
      tbl[k] = mk(1, 1, 0, 32'h0, 0, 32'h4C, 32'h0, 32'h0);
    tbl[18] = mk(1, 0, 0, 32'h0,  0, 32'h4C, 32'h0,  32'h0);
    tbl[19] = mk(1, 0, 0, 32'h0,  0, 32'h50, 32'h0,  32'h0);
    tbl[20] = mk(1, 0, 0, 32'h0,  1, 32'h54, 32'h4C, 32'h13);
    tbl[21] = mk(1, 0, 0, 32'h0,  1, 32'h58, 32'h50, 32'h14);

    // Reset state
    @(negedge clk); #1;
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst imem_addr", bus.imem_addr, 32'h0);
    chk("rst out_pc", bus.out_pc, 32'h0);
    chk("rst out_instr", bus.out_instr, 32'h0);

    // Streaming, redirect to 0x40, halt/resume
    @(negedge clk); rst = 1'b0;
    run_vecs(0, NV - 1);

    // Backpressure from the first valid word
    @(negedge clk); rst = 1'b1; bus.out_ready = 1'b0; bus.halt = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 10) begin
      @(negedge clk); #1; w++;
    end
    chk("bp first valid latency", w, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("bp hold%0d valid", i), {31'b0, bus.out_valid}, 32'h1);
      chk($sformatf("bp hold%0d pc", i), bus.out_pc, 32'h0);
      chk($sformatf("bp hold%0d addr", i), bus.imem_addr, 32'h8);
    end
    @(negedge clk); bus.out_ready = 1'b1; #1;
    chk("bp resume pc0", bus.out_pc, 32'h0);
    @(negedge clk); #1;
    chk("bp resume valid1", {31'b0, bus.out_valid}, 32'h1);
    chk("bp resume pc4", bus.out_pc, 32'h4);
    @(negedge clk); bus.out_ready = 1'b0; #1;
    chk("bp resume valid2", {31'b0, bus.out_valid}, 32'h1);
    chk("bp resume pc8", bus.out_pc, 32'h8);

    // FIFO full (8, C), redirect to unaligned 0x43 with out_ready=0
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h43; #1;
    chk("full hold pc", bus.out_pc, 32'h8);
    chk("full stalled addr", bus.imem_addr, 32'h10);
    @(negedge clk); bus.redirect_valid = 1'b0; bus.redirect_pc = '0; #1;
    chk("flush valid", {31'b0, bus.out_valid}, 32'h0);
    chk("flush addr", bus.imem_addr, 32'h40);
    @(negedge clk); #1;
    chk("flush valid+2", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk); #1;
    chk("redir valid", {31'b0, bus.out_valid}, 32'h1);
    chk("redir pc", bus.out_pc, 32'h40);
    chk("redir instr", bus.out_instr, 32'h10);
    @(negedge clk); #1;
    chk("redir hold pc", bus.out_pc, 32'h40);

    // Async reset pulse between edges while streaming
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pre-rst valid", {31'b0, bus.out_valid}, 32'h1);
    chk("pre-rst pc", bus.out_pc, 32'h44);
    #1; rst = 1'b1; #1;
    chk("async rst valid", {31'b0, bus.out_valid}, 32'h0);
    chk("async rst addr", bus.imem_addr, 32'h0);
    chk("async rst pc", bus.out_pc, 32'h0);
    chk("async rst instr", bus.out_instr, 32'h0);
    #1; rst = 1'b0;
    @(negedge clk);
    run_vecs(0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
